// File: rtl/fight_pkg.sv
// Shared types and constants for round health bookkeeping.
package fight_pkg;

  localparam int HEALTH_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIGHT = 2'd1,
    KO    = 2'd2,
    DONE  = 2'd3
  } fight_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RYU   = 2'b01;
  localparam logic [1:0] WIN_AKUMA = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  function automatic logic [HEALTH_W-1:0] sat_sub(
    input logic [HEALTH_W-1:0] h,
    input logic [HEALTH_W-1:0] d
  );
    return (d >= h) ? '0 : h - d;
  endfunction

endpackage

// File: rtl/health_controller_if.sv
// Hit/frame inputs and health/round status bundle.
interface health_controller_if;
  import fight_pkg::*;

  logic                frame_tick;
  logic                round_start;
  logic                ryu_hit;
  logic [HEALTH_W-1:0] ryu_dmg;
  logic                akuma_hit;
  logic [HEALTH_W-1:0] akuma_dmg;
  logic [HEALTH_W-1:0] RyuHealth;
  logic [HEALTH_W-1:0] AkumaHealth;
  logic                ryu_invuln;
  logic                akuma_invuln;
  logic                fighting;
  logic                round_over;
  logic [1:0]          winner;

  modport master (
    output frame_tick, round_start,
    output ryu_hit, ryu_dmg,
    output akuma_hit, akuma_dmg,
    input  RyuHealth, AkumaHealth,
    input  ryu_invuln, akuma_invuln,
    input  fighting, round_over, winner
  );

  modport slave (
    input  frame_tick, round_start,
    input  ryu_hit, ryu_dmg,
    input  akuma_hit, akuma_dmg,
    output RyuHealth, AkumaHealth,
    output ryu_invuln, akuma_invuln,
    output fighting, round_over, winner
  );

endinterface

// File: rtl/invuln_timer.sv
// Per-fighter invulnerability window, counted in frame ticks.
module invuln_timer #(
  parameter int FRAMES = 30
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic load,
  input  logic frame_tick,
  output logic active
);

  localparam logic [7:0] LOAD_VAL = 8'(FRAMES);

  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_active;

  // A load wins over a same-cycle tick so the window is never short.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear)
      w_cnt_nxt = '0;
    else if (load)
      w_cnt_nxt = LOAD_VAL;
    else if (frame_tick && (r_cnt != '0))
      w_cnt_nxt = r_cnt - 8'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_active <= (w_cnt_nxt != '0);
    end
  end

  assign active = r_active;

endmodule

// File: rtl/health_controller.sv
// Round FSM, saturating damage and KO/winner detection.
module health_controller
  import fight_pkg::*;
#(
  parameter logic [HEALTH_W-1:0] MAX_HEALTH     = 8'd100,
  parameter int                  INVULN_FRAMES  = 30,
  parameter int                  KO_HOLD_FRAMES = 120
) (
  input logic          Clk,
  input logic          Reset,
  health_controller_if.slave bus
);

  localparam logic [7:0] KO_LAST = 8'(KO_HOLD_FRAMES - 1);

  fight_state_t r_state, w_next;

  logic [HEALTH_W-1:0] r_ryu_hp, r_ak_hp;
  logic [7:0]          r_ko_cnt;
  logic [1:0]          r_winner;
  logic                r_fighting, r_round_over;

  logic w_fight, w_start;
  logic w_ryu_inv, w_ak_inv;
  logic w_ryu_acc, w_ak_acc;
  logic w_ko_hit, w_ko_done;

  assign w_fight = (r_state == FIGHT);
  assign w_start = bus.round_start &&
                   ((r_state == IDLE) || (r_state == DONE));

  assign w_ryu_acc = w_fight && !w_ryu_inv &&
                     bus.ryu_hit && (bus.ryu_dmg != '0);
  assign w_ak_acc  = w_fight && !w_ak_inv &&
                     bus.akuma_hit && (bus.akuma_dmg != '0);

  assign w_ko_hit  = w_fight &&
                     ((r_ryu_hp == '0) || (r_ak_hp == '0));
  assign w_ko_done = (r_state == KO) && bus.frame_tick &&
                     (r_ko_cnt == KO_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (bus.round_start) w_next = FIGHT;
      FIGHT: if (w_ko_hit)        w_next = KO;
      KO:    if (w_ko_done)       w_next = DONE;
      DONE:  if (bus.round_start) w_next = FIGHT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_fighting   <= 1'b0;
      r_round_over <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fighting   <= (w_next == FIGHT);
      r_round_over <= (w_next == DONE);
    end
  end

  // Hold counter only runs in KO; any other state parks it at zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_ko_cnt <= '0;
    else if (r_state != KO)
      r_ko_cnt <= '0;
    else if (bus.frame_tick)
      r_ko_cnt <= r_ko_cnt + 8'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ryu_hp <= MAX_HEALTH;
      r_ak_hp  <= MAX_HEALTH;
    end else if (w_start) begin
      r_ryu_hp <= MAX_HEALTH;
      r_ak_hp  <= MAX_HEALTH;
    end else begin
      if (w_ryu_acc) r_ryu_hp <= sat_sub(r_ryu_hp, bus.ryu_dmg);
      if (w_ak_acc)  r_ak_hp  <= sat_sub(r_ak_hp, bus.akuma_dmg);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      r_winner <= WIN_NONE;
    else if (w_start)
      r_winner <= WIN_NONE;
    else if (w_ko_hit)
      r_winner <= {r_ryu_hp == '0, r_ak_hp == '0};
  end

  invuln_timer #(.FRAMES(INVULN_FRAMES)) u_ryu_inv (
    .Clk        (Clk),
    .Reset      (Reset),
    .clear      (w_start),
    .load       (w_ryu_acc),
    .frame_tick (bus.frame_tick),
    .active     (w_ryu_inv)
  );

  invuln_timer #(.FRAMES(INVULN_FRAMES)) u_ak_inv (
    .Clk        (Clk),
    .Reset      (Reset),
    .clear      (w_start),
    .load       (w_ak_acc),
    .frame_tick (bus.frame_tick),
    .active     (w_ak_inv)
  );

  assign bus.RyuHealth    = r_ryu_hp;
  assign bus.AkumaHealth  = r_ak_hp;
  assign bus.ryu_invuln   = w_ryu_inv;
  assign bus.akuma_invuln = w_ak_inv;
  assign bus.fighting     = r_fighting;
  assign bus.round_over   = r_round_over;
  assign bus.winner       = r_winner;

endmodule

// File: tb/tb_health_controller.sv
// Table vectors, directed corner sequences and random play vs a model.
module tb_health_controller;

  localparam int MAXH = 100;
  localparam int INV  = 30;
  localparam int HOLD = 120;

  localparam int P_IDLE  = 0;
  localparam int P_FIGHT = 1;
  localparam int P_KO    = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  health_controller_if hif();

  health_controller #(
    .MAX_HEALTH     (8'd100),
    .INVULN_FRAMES  (INV),
    .KO_HOLD_FRAMES (HOLD)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (hif)
  );

  int n_pass = 0;
  int n_total = 0;

  int m_hp[2];
  int m_inv[2];
  int m_ph, m_ko, m_win;

  typedef struct {
    logic        rs;
    logic        rh;
    logic [7:0]  rd;
    logic        ah;
    logic [7:0]  ad;
    logic        tk;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [21:0] pk(int h0, int h1, int i0,
                                     int i1, int f, int ro, int w);
    return {8'(h0), 8'(h1), 1'(i0), 1'(i1), 1'(f), 1'(ro), 2'(w)};
  endfunction

  function automatic logic [21:0] dut_out();
    return {hif.RyuHealth, hif.AkumaHealth, hif.ryu_invuln,
            hif.akuma_invuln, hif.fighting, hif.round_over,
            hif.winner};
  endfunction

  function automatic logic [21:0] model_out();
    return pk(m_hp[0], m_hp[1], int'(m_inv[0] != 0),
              int'(m_inv[1] != 0), int'(m_ph == P_FIGHT),
              int'(m_ph == P_DONE), m_win);
  endfunction

  task automatic chk(input string name, input logic [21:0] act,
                     input logic [21:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)",
                  name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_hp[0] = MAXH; m_hp[1] = MAXH;
    m_inv[0] = 0;   m_inv[1] = 0;
    m_ph = P_IDLE;  m_ko = 0; m_win = 0;
  endtask

  // One clock of round rules, evaluated from the pre-edge snapshot.
  task automatic model_step(input bit rs, input bit rh, input int rd,
                            input bit ah, input int ad, input bit tk);
    int  ph0;
    bit  acc[2];
    int  dmg[2];
    ph0 = m_ph;
    dmg[0] = rd; dmg[1] = ad;
    acc[0] = (ph0 == P_FIGHT) && m_inv[0] == 0 && rh && rd != 0;
    acc[1] = (ph0 == P_FIGHT) && m_inv[1] == 0 && ah && ad != 0;
    if (ph0 == P_FIGHT && (m_hp[0] == 0 || m_hp[1] == 0)) begin
      m_win = (m_hp[1] == 0 ? 1 : 0) + (m_hp[0] == 0 ? 2 : 0);
      m_ph = P_KO;
      m_ko = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        m_hp[i] = (dmg[i] >= m_hp[i]) ? 0 : m_hp[i] - dmg[i];
        m_inv[i] = INV;
      end else if (tk && m_inv[i] > 0) begin
        m_inv[i]--;
      end
    end
    if (ph0 == P_KO && tk) begin
      m_ko++;
      if (m_ko == HOLD) m_ph = P_DONE;
    end
    if ((ph0 == P_IDLE || ph0 == P_DONE) && rs) begin
      m_ph = P_FIGHT;
      m_hp[0] = MAXH; m_hp[1] = MAXH;
      m_inv[0] = 0;   m_inv[1] = 0;
      m_win = 0;
    end
  endtask

  task automatic apply(input bit rs, input bit rh, input int rd,
                       input bit ah, input int ad, input bit tk);
    hif.round_start = rs;
    hif.ryu_hit     = rh;
    hif.ryu_dmg     = 8'(rd);
    hif.akuma_hit   = ah;
    hif.akuma_dmg   = 8'(ad);
    hif.frame_tick  = tk;
    @(posedge clk);
    model_step(rs, rh, rd, ah, ad, tk);
    #1;
    chk("model", dut_out(), model_out());
  endtask

  task automatic idle_inputs();
    hif.round_start = 0; hif.frame_tick = 0;
    hif.ryu_hit = 0;     hif.ryu_dmg = '0;
    hif.akuma_hit = 0;   hif.akuma_dmg = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset", dut_out(), pk(MAXH, MAXH, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 8'd10, 1'b1, 8'd5, 1'b0,
               pk(100, 100, 0, 0, 0, 0, 0)};
    tbl[1] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0,
               pk(100, 100, 0, 0, 1, 0, 0)};
    tbl[2] = '{1'b0, 1'b1, 8'd10, 1'b0, 8'd0, 1'b0,
               pk(90, 100, 1, 0, 1, 0, 0)};
    tbl[3] = '{1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0,
               pk(90, 100, 1, 0, 1, 0, 0)};
    tbl[4] = '{1'b0, 1'b1, 8'd50, 1'b1, 8'd7, 1'b0,
               pk(90, 93, 1, 1, 1, 0, 0)};
    tbl[5] = '{1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1,
               pk(90, 93, 1, 1, 1, 0, 0)};
    tbl[6] = '{1'b0, 1'b1, 8'd255, 1'b1, 8'd255, 1'b1,
               pk(90, 93, 1, 1, 1, 0, 0)};
    tbl[7] = '{1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0,
               pk(90, 93, 1, 1, 1, 0, 0)};

    idle_inputs();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].rs, tbl[i].rh, int'(tbl[i].rd),
            tbl[i].ah, int'(tbl[i].ad), tbl[i].tk);
      chk($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Invulnerability window boundary.
    do_reset();
    apply(1, 0, 0, 0, 0, 0);
    chk("start", dut_out(), pk(100, 100, 0, 0, 1, 0, 0));
    apply(0, 1, 10, 0, 0, 0);
    chk("ryu_hit10", dut_out(), pk(90, 100, 1, 0, 1, 0, 0));
    repeat (29) apply(0, 0, 0, 0, 0, 1);
    apply(0, 1, 10, 0, 0, 0);
    chk("hit_at_29", dut_out(), pk(90, 100, 1, 0, 1, 0, 0));
    apply(0, 0, 0, 0, 0, 1);
    chk("inv_end_30", dut_out(), pk(90, 100, 0, 0, 1, 0, 0));
    apply(0, 1, 10, 0, 0, 0);
    chk("hit_after_30", dut_out(), pk(80, 100, 1, 0, 1, 0, 0));

    // Saturating KO, hold time and restart from DONE.
    apply(0, 0, 0, 1, 95, 0);
    repeat (30) apply(0, 0, 0, 0, 0, 1);
    apply(0, 0, 0, 1, 200, 0);
    chk("sat_no_wrap", dut_out(), pk(80, 0, 0, 1, 1, 0, 0));
    apply(0, 0, 0, 0, 0, 0);
    chk("ko_win_ryu", dut_out(), pk(80, 0, 0, 1, 0, 0, 1));
    repeat (119) apply(0, 0, 0, 0, 0, 1);
    chk("ko_hold_119", dut_out(), pk(80, 0, 0, 0, 0, 0, 1));
    apply(0, 0, 0, 0, 0, 1);
    chk("done_120", dut_out(), pk(80, 0, 0, 0, 0, 1, 1));
    apply(0, 0, 0, 1, 10, 0);
    chk("hit_in_done", dut_out(), pk(80, 0, 0, 0, 0, 1, 1));
    apply(1, 0, 0, 0, 0, 0);
    chk("restart", dut_out(), pk(100, 100, 0, 0, 1, 0, 0));

    // Double KO gives a draw; later hits are ignored.
    apply(0, 1, 90, 1, 90, 0);
    repeat (30) apply(0, 0, 0, 0, 0, 1);
    apply(0, 1, 10, 1, 10, 0);
    chk("double_ko", dut_out(), pk(0, 0, 1, 1, 1, 0, 0));
    apply(0, 0, 0, 0, 0, 0);
    chk("draw", dut_out(), pk(0, 0, 1, 1, 0, 0, 3));
    repeat (30) apply(0, 0, 0, 0, 0, 1);
    apply(0, 1, 50, 1, 50, 0);
    chk("hit_in_ko", dut_out(), pk(0, 0, 0, 0, 0, 0, 3));

    // Asynchronous reset between edges while in KO.
    idle_inputs();
    @(posedge clk);
    model_step(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk("async_rst", dut_out(), pk(100, 100, 0, 0, 0, 0, 0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Random play against the model.
    apply(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      bit rs, rh, ah, tk;
      int rd, ad;
      rs = ($urandom % 64) == 0;
      rh = ($urandom % 3) == 0;
      ah = ($urandom % 3) == 0;
      tk = ($urandom % 2) == 0;
      rd = ($urandom % 4 == 0) ? 0 :
           (($urandom % 2) ? int'($urandom % 256) : int'($urandom % 20));
      ad = ($urandom % 4 == 0) ? 0 :
           (($urandom % 2) ? int'($urandom % 256) : int'($urandom % 20));
      apply(rs, rh, rd, ah, ad, tk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
